vram_arbiter: RTL and testbench
===============================

# vram_arbiter

Single-port video RAM arbiter for the pixel pipeline. It shares one synchronous-read framebuffer RAM between display scan-out, which is driven by the horizontal/vertical sync generators' visible flags, and CPU accesses. Display fetches own the RAM during the active picture. CPU writes are posted into a small FIFO and drained in blanking. CPU reads are single-outstanding and ordered behind all posted writes.

## Interface
Parameters:
- ADDR_W, 15, framebuffer address width
- DATA_W, 8, pixel/data width
- FIFO_DEPTH, 4, posted-write FIFO entries; power of two, ≥2

Ports:
- clk  in  1  pixel clock
- rstN  in  1  reset, asynchronous, active-low
- hVisible  in  1  horizontal visible region
- vVisible  in  1  vertical visible region
- dispReq  in  1  display fetch request, sampled each cycle
- dispAddr  in  ADDR_W  display fetch address
- dispGrant  out  1  display slot granted this cycle
- dispValid  out  1  display read data valid
- dispData  out  DATA_W  display read data
- cpuReq  in  1  CPU access request
- cpuWe  in  1  1 = write, 0 = read
- cpuAddr  in  ADDR_W  CPU address
- cpuWdata  in  DATA_W  CPU write data
- cpuReady  out  1  CPU request accepted when cpuReq && cpuReady
- cpuRvalid  out  1  CPU read data valid (1-cycle pulse)
- cpuRdata  out  DATA_W  CPU read data
- ramAddr  out  ADDR_W  RAM address (registered)
- ramWe  out  1  RAM write enable (registered)
- ramWdata  out  DATA_W  RAM write data (registered)
- ramRdata  in  DATA_W  RAM read data, valid 1 cycle after address

## Operation
- active = hVisible && vVisible.
- cpuReady is combinational:
  - Write: cpuReady = !fifoFull && !rdBusy.
  - Read: cpuReady = fifoEmpty && !rdBusy.
  - No full-FIFO bypass, even if a pop occurs in the same cycle.
- Accepted write: {cpuAddr, cpuWdata} pushed into the FIFO.
- Accepted read: address latched, rdBusy set.
- One slot per cycle, fixed priority:
  1. dispReq && active → display slot.
  2. FIFO non-empty → write slot (pop head).
  3. rdBusy → read slot; rdBusy clears at end of this cycle.
  4. dispReq (blanking) → display slot.
  5. Otherwise idle: ramWe = 0, ramAddr holds.
- dispGrant = 1 in any cycle where a display slot is granted. Display requests that are not granted are dropped, not queued.
- Push and pop in the same cycle leaves the count unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH. The count is ADDR-independent and uses log2(FIFO_DEPTH)+1 bits.
- Ordering: reads are accepted only with the FIFO empty, so a read always observes every previously accepted write.
- A new write may be accepted in the cycle after the read slot, before cpuRvalid.
- Each data-return pipeline stage carries a tag (display / CPU read / none). Writes return nothing.

## Timing
- Slot granted in cycle T:
  - ramAddr/ramWe/ramWdata driven in T+1.
  - ramRdata returns in T+2.
  - dispData/cpuRdata registered, with dispValid/cpuRvalid high for exactly one cycle, in T+3.
- Fixed latency of 3 cycles from slot grant to data valid. There is no backpressure on the data outputs.
- During active with dispReq every cycle, CPU work never issues. Posted writes wait for blanking; the FIFO may fill and deassert cpuReady.
- A FIFO drains at 1 entry per cycle once it holds priority.
- Reset (rstN low, asynchronous):
  - Values: FIFO empty, rdBusy = 0, pipeline tags cleared, ramWe = 0, ramAddr = 0, ramWdata = 0, dispValid = 0, cpuRvalid = 0, dispData = 0, cpuRdata = 0, dispGrant = 0.
  - A reset mid-operation discards pending writes and the read. No cpuRvalid follows.
  - cpuReady is 1 immediately after release.

## Test plan
- Reset: assert rstN low between edges with 2 writes queued → all outputs 0 at once; after release cpuReady = 1, ramWe stays 0, no RAM writes occur.
- Display latency: active, dispReq = 1 for one cycle with dispAddr = 0x0123, RAM model returns address low byte → dispGrant that cycle, ramAddr = 0x0123 next cycle, dispValid = 1 with dispData = 0x23 exactly 3 cycles after the grant.
- FIFO full under active: active with dispReq every cycle, CPU writes 5 words → 4 accepted, cpuReady = 0 on the 5th, ramWe never high. Drop hVisible → 4 ramWe pulses in 4 consecutive cycles, in order, then the 5th write accepted.
- Read-after-write ordering: blanking, write 0xAA then 0x55 to 0x0010, then read 0x0010 → read held until FIFO empty, cpuRvalid pulses once with cpuRdata = 0x55.
- Blanking priority: blanking, 3 writes posted, dispReq held → dispGrant = 0 for 3 cycles, then 1; the same dispReq in active is granted immediately while the writes wait.
- Simultaneous push/pop: FIFO holds 3 entries in blanking, a write is accepted in the same cycle as a pop → count stays 3, no loss; entries drain in FIFO order.

Source files
------------

// File: rtl/vram_arbiter.sv
// ---------------------------------------------------------------------------
// vram_arbiter
//
// Shares one single-port, synchronous-read framebuffer RAM between display
// scan-out and CPU accesses. Display fetches own the RAM during the active
// picture. CPU writes are posted into a small FIFO and drained whenever no
// active-region display fetch wants the slot. CPU reads are single
// outstanding and only accepted with the FIFO empty, so a read always sees
// every write accepted before it.
//
// Ports
//   clk, rstN                    pixel clock, async active-low reset
//   hVisible, vVisible           sync generator visible flags
//   dispReq/dispAddr             display fetch request (dropped if not granted)
//   dispGrant                    display slot granted this cycle (comb)
//   dispValid/dispData           display read return, 3 cycles after grant
//   cpuReq/cpuWe/cpuAddr/cpuWdata CPU request, accepted on cpuReq && cpuReady
//   cpuReady                     CPU accept (comb)
//   cpuRvalid/cpuRdata           CPU read return, 1-cycle pulse
//   ramAddr/ramWe/ramWdata       registered RAM command
//   ramRdata                     RAM read data, one cycle after ramAddr
//
// Slot kinds chosen each cycle (fixed priority, top wins):
//   slot      | meaning
//   SLOT_DISP | display fetch in the active picture
//   SLOT_WR   | pop FIFO head and write it to RAM
//   SLOT_RD   | issue the pending CPU read
//   SLOT_DISP | display fetch in blanking
//   SLOT_IDLE | nothing issued, ramAddr holds, ramWe low
// ---------------------------------------------------------------------------
module vram_arbiter #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              hVisible,
  input  logic              vVisible,
  input  logic              dispReq,
  input  logic [ADDR_W-1:0] dispAddr,
  output logic              dispGrant,
  output logic              dispValid,
  output logic [DATA_W-1:0] dispData,
  input  logic              cpuReq,
  input  logic              cpuWe,
  input  logic [ADDR_W-1:0] cpuAddr,
  input  logic [DATA_W-1:0] cpuWdata,
  output logic              cpuReady,
  output logic              cpuRvalid,
  output logic [DATA_W-1:0] cpuRdata,
  output logic [ADDR_W-1:0] ramAddr,
  output logic              ramWe,
  output logic [DATA_W-1:0] ramWdata,
  input  logic [DATA_W-1:0] ramRdata
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    SLOT_IDLE = 2'd0,
    SLOT_DISP = 2'd1,
    SLOT_WR   = 2'd2,
    SLOT_RD   = 2'd3
  } slot_e;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_DISP = 2'd1,
    TAG_CPU  = 2'd2
  } tag_e;

  // Posted-write FIFO
  logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  // Pending CPU read
  logic              r_rd_busy;
  logic [ADDR_W-1:0] r_rd_addr;

  // RAM command stage and return pipeline tags
  logic [ADDR_W-1:0] r_ram_addr;
  logic              r_ram_we;
  logic [DATA_W-1:0] r_ram_wdata;
  tag_e              r_tag1;
  tag_e              r_tag2;

  // Registered data returns
  logic              r_disp_valid;
  logic [DATA_W-1:0] r_disp_data;
  logic              r_cpu_rvalid;
  logic [DATA_W-1:0] r_cpu_rdata;

  logic  w_active;
  logic  w_fifo_empty;
  logic  w_fifo_full;
  logic  w_cpu_ready;
  logic  w_push;
  logic  w_pop;
  logic  w_rd_accept;
  slot_e w_slot;

  assign w_active     = hVisible && vVisible;
  assign w_fifo_empty = (r_count == '0);
  assign w_fifo_full  = (r_count == CNT_W'(FIFO_DEPTH));

  // Fullness is judged on the registered count only: a pop in the same
  // cycle does not open a slot for a write to a full FIFO.
  assign w_cpu_ready = cpuWe ? (!w_fifo_full && !r_rd_busy)
                             : (w_fifo_empty && !r_rd_busy);

  assign w_push      = cpuReq && w_cpu_ready && cpuWe;
  assign w_rd_accept = cpuReq && w_cpu_ready && !cpuWe;

  always_comb begin
    w_slot = SLOT_IDLE;
    if (dispReq && w_active) begin
      w_slot = SLOT_DISP;
    end else if (!w_fifo_empty) begin
      w_slot = SLOT_WR;
    end else if (r_rd_busy) begin
      w_slot = SLOT_RD;
    end else if (dispReq) begin
      w_slot = SLOT_DISP;
    end
  end

  assign w_pop = (w_slot == SLOT_WR);

  // FIFO control
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= cpuAddr;
      r_fifo_data[r_wr_ptr] <= cpuWdata;
    end
  end

  // Single-outstanding CPU read
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_rd_busy <= 1'b0;
      r_rd_addr <= '0;
    end else if (w_rd_accept) begin
      r_rd_busy <= 1'b1;
      r_rd_addr <= cpuAddr;
    end else if (w_slot == SLOT_RD) begin
      r_rd_busy <= 1'b0;
    end
  end

  // RAM command stage
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_ram_addr  <= '0;
      r_ram_we    <= 1'b0;
      r_ram_wdata <= '0;
      r_tag1      <= TAG_NONE;
    end else begin
      case (w_slot)
        SLOT_DISP: begin
          r_ram_addr <= dispAddr;
          r_ram_we   <= 1'b0;
          r_tag1     <= TAG_DISP;
        end
        SLOT_WR: begin
          r_ram_addr  <= r_fifo_addr[r_rd_ptr];
          r_ram_wdata <= r_fifo_data[r_rd_ptr];
          r_ram_we    <= 1'b1;
          r_tag1      <= TAG_NONE;
        end
        SLOT_RD: begin
          r_ram_addr <= r_rd_addr;
          r_ram_we   <= 1'b0;
          r_tag1     <= TAG_CPU;
        end
        default: begin
          r_ram_we <= 1'b0;
          r_tag1   <= TAG_NONE;
        end
      endcase
    end
  end

  // Tag follows the RAM access while ramRdata is being produced, then
  // steers the returned word to the display or CPU output register.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_tag2       <= TAG_NONE;
      r_disp_valid <= 1'b0;
      r_disp_data  <= '0;
      r_cpu_rvalid <= 1'b0;
      r_cpu_rdata  <= '0;
    end else begin
      r_tag2       <= r_tag1;
      r_disp_valid <= (r_tag2 == TAG_DISP);
      r_cpu_rvalid <= (r_tag2 == TAG_CPU);
      if (r_tag2 == TAG_DISP) r_disp_data <= ramRdata;
      if (r_tag2 == TAG_CPU)  r_cpu_rdata <= ramRdata;
    end
  end

  assign dispGrant = (w_slot == SLOT_DISP);
  assign cpuReady  = w_cpu_ready;
  assign ramAddr   = r_ram_addr;
  assign ramWe     = r_ram_we;
  assign ramWdata  = r_ram_wdata;
  assign dispValid = r_disp_valid;
  assign dispData  = r_disp_data;
  assign cpuRvalid = r_cpu_rvalid;
  assign cpuRdata  = r_cpu_rdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vram_arbiter
//
// Directed stimulus with a scoreboard. Stimulus pushes expected RAM writes
// and CPU read data into queues; display expectations (data and return
// cycle) are pushed when a grant is observed. A negedge monitor pops and
// compares whenever ramWe, dispValid or cpuRvalid is high. The RAM model
// returns the low address byte for never-written locations.
// ---------------------------------------------------------------------------
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        rstN;
  logic        hVisible, vVisible;
  logic        dispReq;
  logic [14:0] dispAddr;
  logic        dispGrant, dispValid;
  logic [7:0]  dispData;
  logic        cpuReq, cpuWe;
  logic [14:0] cpuAddr;
  logic [7:0]  cpuWdata;
  logic        cpuReady, cpuRvalid;
  logic [7:0]  cpuRdata;
  logic [14:0] ramAddr;
  logic        ramWe;
  logic [7:0]  ramWdata;
  logic [7:0]  ramRdata;

  vram_arbiter dut (
    .clk(clk), .rstN(rstN),
    .hVisible(hVisible), .vVisible(vVisible),
    .dispReq(dispReq), .dispAddr(dispAddr),
    .dispGrant(dispGrant), .dispValid(dispValid), .dispData(dispData),
    .cpuReq(cpuReq), .cpuWe(cpuWe), .cpuAddr(cpuAddr), .cpuWdata(cpuWdata),
    .cpuReady(cpuReady), .cpuRvalid(cpuRvalid), .cpuRdata(cpuRdata),
    .ramAddr(ramAddr), .ramWe(ramWe), .ramWdata(ramWdata), .ramRdata(ramRdata)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM model
  logic [7:0] mem   [32768];
  bit         mem_v [32768];
  always @(posedge clk) begin
    ramRdata <= mem_v[ramAddr] ? mem[ramAddr] : ramAddr[7:0];
    if (ramWe) begin
      mem[ramAddr]   <= ramWdata;
      mem_v[ramAddr] <= 1'b1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  logic [22:0] wq[$];
  logic [7:0]  rq[$];
  logic [7:0]  dq_dat[$];
  int          dq_cyc[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rstN) begin
      if (dispValid) begin
        check("disp_expected", 64'(dq_dat.size() > 0), 64'(1));
        if (dq_dat.size() > 0) begin
          check("disp_cycle", 64'(cyc), 64'(dq_cyc.pop_front()));
          check("disp_data", 64'(dispData), 64'(dq_dat.pop_front()));
        end
      end
      if (ramWe) begin
        check("write_expected", 64'(wq.size() > 0), 64'(1));
        if (wq.size() > 0) check("ram_write", 64'({ramAddr, ramWdata}), 64'(wq.pop_front()));
      end
      if (cpuRvalid) begin
        check("rvalid_expected", 64'(rq.size() > 0), 64'(1));
        if (rq.size() > 0) check("cpu_rdata", 64'(cpuRdata), 64'(rq.pop_front()));
      end
      if (dispGrant) begin
        dq_cyc.push_back(cyc + 3);
        dq_dat.push_back(dispAddr[7:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic cpu_write(input logic [14:0] a, input logic [7:0] d, output int waits);
    waits = 0;
    cpuReq = 1'b1; cpuWe = 1'b1; cpuAddr = a; cpuWdata = d;
    @(negedge clk);
    while (!cpuReady && waits < 50) begin
      tick();
      @(negedge clk);
      waits++;
    end
    check("write_accept", 64'(cpuReady), 64'(1));
    if (cpuReady) wq.push_back({a, d});
    tick();
    cpuReq = 1'b0;
  endtask

  task automatic cpu_read(input logic [14:0] a, input logic [7:0] exp, output int waits);
    waits = 0;
    cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = a;
    @(negedge clk);
    while (!cpuReady && waits < 50) begin
      tick();
      @(negedge clk);
      waits++;
    end
    check("read_accept", 64'(cpuReady), 64'(1));
    if (cpuReady) rq.push_back(exp);
    tick();
    cpuReq = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int we_cnt;
    rstN = 1'b1;
    hVisible = 1'b0; vVisible = 1'b0;
    dispReq = 1'b0; dispAddr = '0;
    cpuReq = 1'b0; cpuWe = 1'b0; cpuAddr = '0; cpuWdata = '0;
    #2 rstN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs",
          64'({ramAddr, ramWe, ramWdata, dispValid, cpuRvalid, dispData, cpuRdata, dispGrant}), 64'(0));
    rstN = 1'b1;
    #1;
    check("ready_after_reset", 64'(cpuReady), 64'(1));
    idle(2);

    // Display latency
    hVisible = 1'b1; vVisible = 1'b1; dispReq = 1'b1; dispAddr = 15'h0123;
    @(negedge clk);
    check("disp_grant", 64'(dispGrant), 64'(1));
    tick();
    dispReq = 1'b0;
    @(negedge clk);
    check("disp_ram_addr", 64'(ramAddr), 64'(15'h0123));
    check("disp_ram_we", 64'(ramWe), 64'(0));
    idle(6);

    // FIFO full under active display
    tick();
    dispReq = 1'b1; dispAddr = 15'h0241;
    we_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      cpuReq = 1'b1; cpuWe = 1'b1;
      cpuAddr = 15'h0100 + 15'(k); cpuWdata = 8'hB0 + 8'(k);
      @(negedge clk);
      if (ramWe) we_cnt++;
      check("full_ready", 64'(cpuReady), 64'(k < 4));
      if (cpuReady) wq.push_back({cpuAddr, cpuWdata});
      if (k < 4) tick();
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      if (ramWe) we_cnt++;
      check("full_hold_ready", 64'(cpuReady), 64'(0));
    end
    check("active_no_ram_write", 64'(we_cnt), 64'(0));
    tick();
    hVisible = 1'b0;
    @(negedge clk);
    check("no_full_bypass", 64'(cpuReady), 64'(0));
    tick();
    @(negedge clk);
    check("fifth_accept", 64'(cpuReady), 64'(1));
    if (cpuReady) wq.push_back({cpuAddr, cpuWdata});
    check("drain_we", 64'(ramWe), 64'(1));
    tick();
    cpuReq = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("drain_we", 64'(ramWe), 64'(1));
      tick();
    end
    dispReq = 1'b0;
    idle(8);

    // Read-after-write ordering in blanking
    cpu_write(15'h0010, 8'hAA, w);
    check("raw_wr1_wait", 64'(w), 64'(0));
    cpu_write(15'h0010, 8'h55, w);
    check("raw_wr2_wait", 64'(w), 64'(0));
    cpu_read(15'h0010, 8'h55, w);
    check("raw_read_held", 64'(w), 64'(1));
    idle(10);

    // Blanking priority versus active grant
    hVisible = 1'b1; dispReq = 1'b1; dispAddr = 15'h0300;
    for (int i = 0; i < 3; i++) begin
      cpuReq = 1'b1; cpuWe = 1'b1;
      cpuAddr = 15'h0020 + 15'(i); cpuWdata = 8'hC0 + 8'(i);
      @(negedge clk);
      check("prio_ready", 64'(cpuReady), 64'(1));
      if (cpuReady) wq.push_back({cpuAddr, cpuWdata});
      check("active_grant", 64'(dispGrant), 64'(1));
      tick();
    end
    cpuReq = 1'b0; hVisible = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("blank_grant", 64'(dispGrant), 64'(i == 3));
      tick();
    end
    dispReq = 1'b0;
    idle(8);

    // Simultaneous push and pop
    hVisible = 1'b1; dispReq = 1'b1; dispAddr = 15'h0301;
    for (int i = 0; i < 6; i++) begin
      cpuReq = 1'b1; cpuWe = 1'b1;
      cpuAddr = 15'h0030 + 15'(i); cpuWdata = 8'hD0 + 8'(i);
      hVisible = (i == 3) ? 1'b0 : 1'b1;
      @(negedge clk);
      check("pushpop_ready", 64'(cpuReady), 64'(i < 5));
      if (cpuReady) wq.push_back({cpuAddr, cpuWdata});
      tick();
    end
    cpuReq = 1'b0; hVisible = 1'b0; dispReq = 1'b0;
    idle(10);

    // Reset mid-operation with two writes queued
    hVisible = 1'b1; dispReq = 1'b1; dispAddr = 15'h0302;
    cpu_write(15'h0040, 8'hE0, w);
    cpu_write(15'h0041, 8'hE1, w);
    #2;
    rstN = 1'b0; dispReq = 1'b0; cpuReq = 1'b0;
    #1;
    check("midreset_outputs",
          64'({ramAddr, ramWe, ramWdata, dispValid, cpuRvalid, dispData, cpuRdata, dispGrant}), 64'(0));
    wq.delete(); rq.delete(); dq_dat.delete(); dq_cyc.delete();
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b1;
    hVisible = 1'b0;
    cpuWe = 1'b0;
    #1;
    check("midreset_ready_rd", 64'(cpuReady), 64'(1));
    cpuWe = 1'b1;
    #1;
    check("midreset_ready_wr", 64'(cpuReady), 64'(1));
    we_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ramWe) we_cnt++;
      tick();
    end
    check("midreset_no_write", 64'(we_cnt), 64'(0));

    w = 0;
    while ((wq.size() + rq.size() + dq_dat.size()) != 0 && w < 50) begin
      tick();
      w++;
    end
    check("writes_drained", 64'(wq.size()), 64'(0));
    check("reads_drained", 64'(rq.size()), 64'(0));
    check("disp_drained", 64'(dq_dat.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
